// File: rtl/usb2_ext_out_drain_if.sv
// usb2_ext_out_drain_if
//   Bundles the endpoint 2 OUT buffer read/release port and the outgoing
//   byte stream used by usb2_ext_out_drain.
//   master : the drain (drives address, arm and the stream side).
//   slave  : the buffer plus the stream sink.
//   Buffer : ext_buf_out_hasdata, ext_buf_out_len, ext_buf_out_addr,
//            ext_buf_out_q (1-cycle read latency), ext_buf_out_arm,
//            ext_buf_out_arm_ack.
//   Stream : out_data, out_valid, out_last, out_ready.
interface usb2_ext_out_drain_if #(
  parameter int ADDR_W = 9
);
  logic              ext_buf_out_hasdata;
  logic [9:0]        ext_buf_out_len;
  logic [ADDR_W-1:0] ext_buf_out_addr;
  logic [7:0]        ext_buf_out_q;
  logic              ext_buf_out_arm;
  logic              ext_buf_out_arm_ack;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  ext_buf_out_hasdata, ext_buf_out_len, ext_buf_out_q,
           ext_buf_out_arm_ack, out_ready,
    output ext_buf_out_addr, ext_buf_out_arm, out_data, out_valid, out_last
  );

  modport slave (
    output ext_buf_out_hasdata, ext_buf_out_len, ext_buf_out_q,
           ext_buf_out_arm_ack, out_ready,
    input  ext_buf_out_addr, ext_buf_out_arm, out_data, out_valid, out_last
  );
endinterface

// File: rtl/usb2_ext_out_drain.sv
// usb2_ext_out_drain
//   Drains committed packets from the endpoint 2 OUT buffer on the ext_clk
//   side: reads the packet bytes through the 1-cycle-latency read port,
//   emits them as a valid/ready stream with last, then releases the buffer
//   with a 4-phase arm/arm_ack handshake.
//   Ports:
//     ext_clk, reset      clock and synchronous active-high reset
//     drain_en            allows a new packet to start
//     bus (master)        buffer read/release port and output stream
//     pkt_done, pkt_len   completion pulse and byte count of the packet
//     err_overlen         pulse when the buffer reports len > MAX_LEN
//     err_arm_timeout     pulse when an arm handshake phase times out
module usb2_ext_out_drain #(
  parameter int MAX_LEN     = 512,
  parameter int ADDR_W      = 9,
  parameter int ARM_TIMEOUT = 1024
) (
  input  logic                  ext_clk,
  input  logic                  reset,
  input  logic                  drain_en,
  usb2_ext_out_drain_if.master  bus,
  output logic                  pkt_done,
  output logic [9:0]            pkt_len,
  output logic                  err_overlen,
  output logic                  err_arm_timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] ARM     = 2'd2;
  localparam logic [1:0] ARM_CLR = 2'd3;

  localparam logic [9:0]       MAX_LEN_V = 10'(MAX_LEN);
  localparam int               TMR_W     = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ARM_TIMEOUT - 1);

  logic [1:0]        state;
  logic [9:0]        len_q;
  logic [9:0]        rd_cnt;
  logic [9:0]        tx_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              issue_q;
  logic              ret_valid;
  logic              arm_q;
  logic [TMR_W-1:0]  timer;
  logic [1:0]        skid_cnt;
  logic [7:0]        skid_data [2];

  logic              start;
  logic              over;
  logic              head_valid;
  logic [7:0]        head_data;
  logic              pop;
  logic              is_last;
  logic [2:0]        occ;
  logic              issue;
  logic              pop_skid;
  logic              push;

  assign start = (state == IDLE) && drain_en && bus.ext_buf_out_hasdata;
  assign over  = bus.ext_buf_out_len > MAX_LEN_V;
  assign err_overlen = start && over && !reset;

  // The returning read byte is presented directly when the skid buffer is
  // empty, so the first beat appears in the same cycle its data returns.
  // A returned byte that is not taken that cycle drops into the skid buffer.
  assign head_valid = (skid_cnt != 2'd0) || ret_valid;
  assign head_data  = (skid_cnt != 2'd0) ? skid_data[0] : bus.ext_buf_out_q;
  assign pop        = head_valid && bus.out_ready;
  assign is_last    = (tx_cnt == len_q - 10'd1);

  assign bus.out_valid        = head_valid;
  assign bus.out_data         = head_valid ? head_data : 8'd0;
  assign bus.out_last         = head_valid && is_last;
  assign bus.ext_buf_out_addr = addr_q;
  assign bus.ext_buf_out_arm  = arm_q;

  // Buffered plus in-flight bytes are limited to two. The byte leaving this
  // cycle frees its slot, which keeps 1 byte/cycle with out_ready held high.
  assign occ   = {1'b0, skid_cnt} + {2'b00, ret_valid} + {2'b00, issue_q};
  assign issue = (state == READ) && (rd_cnt < len_q) &&
                 (occ < (3'd2 + {2'b00, pop}));

  assign pop_skid = pop && (skid_cnt != 2'd0);
  assign push     = ret_valid && !(pop && (skid_cnt == 2'd0));

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      skid_cnt     <= 2'd0;
      skid_data[0] <= 8'd0;
      skid_data[1] <= 8'd0;
    end else begin
      case ({pop_skid, push})
        2'b01: begin
          skid_data[skid_cnt[0]] <= bus.ext_buf_out_q;
          skid_cnt               <= skid_cnt + 2'd1;
        end
        2'b10: begin
          skid_data[0] <= skid_data[1];
          skid_cnt     <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_data[0] <= bus.ext_buf_out_q;
          end else begin
            skid_data[0] <= skid_data[1];
            skid_data[1] <= bus.ext_buf_out_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state           <= IDLE;
      len_q           <= 10'd0;
      rd_cnt          <= 10'd0;
      tx_cnt          <= 10'd0;
      addr_q          <= '0;
      issue_q         <= 1'b0;
      ret_valid       <= 1'b0;
      arm_q           <= 1'b0;
      timer           <= '0;
      pkt_done        <= 1'b0;
      pkt_len         <= 10'd0;
      err_arm_timeout <= 1'b0;
    end else begin
      pkt_done        <= 1'b0;
      err_arm_timeout <= 1'b0;
      issue_q         <= issue;
      ret_valid       <= issue_q;
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= over ? MAX_LEN_V : bus.ext_buf_out_len;
            rd_cnt <= 10'd0;
            tx_cnt <= 10'd0;
            state  <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= rd_cnt[ADDR_W-1:0];
            rd_cnt <= rd_cnt + 10'd1;
          end
          if (pop) begin
            tx_cnt <= tx_cnt + 10'd1;
          end
          if ((len_q == 10'd0) || (pop && is_last)) begin
            pkt_done <= 1'b1;
            pkt_len  <= len_q;
            arm_q    <= 1'b1;
            timer    <= '0;
            state    <= ARM;
          end
        end
        ARM: begin
          if (bus.ext_buf_out_arm_ack) begin
            arm_q <= 1'b0;
            timer <= '0;
            state <= ARM_CLR;
          end else if (timer == TMR_LAST) begin
            err_arm_timeout <= 1'b1;
            arm_q           <= 1'b0;
            state           <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARM_CLR: begin
          if (!bus.ext_buf_out_arm_ack) begin
            state <= IDLE;
          end else if (timer == TMR_LAST) begin
            err_arm_timeout <= 1'b1;
            state           <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ext_out_drain.sv
// tb_usb2_ext_out_drain
//   Self-checking bench for usb2_ext_out_drain: a table of packet scenarios
//   with expected beat counts, randomized packets checked against an
//   expected-byte queue built from the buffer contents, and hand-written
//   sequences for arm timeout and reset in the middle of a packet.
module tb_usb2_ext_out_drain;

  logic       ext_clk;
  logic       reset;
  logic       drain_en;
  logic       pkt_done;
  logic [9:0] pkt_len;
  logic       err_overlen;
  logic       err_arm_timeout;

  usb2_ext_out_drain_if #(.ADDR_W(9)) bus ();

  usb2_ext_out_drain #(
    .MAX_LEN(512), .ADDR_W(9), .ARM_TIMEOUT(1024)
  ) dut (
    .ext_clk(ext_clk),
    .reset(reset),
    .drain_en(drain_en),
    .bus(bus),
    .pkt_done(pkt_done),
    .pkt_len(pkt_len),
    .err_overlen(err_overlen),
    .err_arm_timeout(err_arm_timeout)
  );

  typedef struct {
    int len;
    int ready_mode;
    int ack_delay;
    int exp_beats;
    int exp_pkt_len;
    bit exp_overlen;
  } vec_t;

  logic [7:0] mem [512];
  logic [7:0] exp_q [$];
  vec_t       vecs [7];
  int         checks = 0;
  int         errors = 0;

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  // Buffer model with a registered read port
  always @(posedge ext_clk) bus.ext_buf_out_q <= mem[bus.ext_buf_out_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic fillMem();
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
  endtask

  // Runs one packet from the IDLE cycle through the release handshake and
  // checks the stream against the expected bytes mem[0 .. exp_beats-1].
  task automatic applyStimulus(input int len, input int ready_mode,
                               input int ack_delay, input int exp_beats,
                               input int exp_pkt_len, input bit exp_overlen);
    int   cycle = 0, beats = 0, done_cnt = 0, ov_cnt = 0, to_cnt = 0;
    int   first_valid = -1, last_beat = -1, done_cycle = -1, arm_cnt = 0;
    int   max_addr = 0;
    bit   finished = 0, prev_stall = 0, prev_last = 0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] want;
    fillMem();
    exp_q.delete();
    for (int i = 0; i < exp_beats; i++) exp_q.push_back(mem[i]);
    while (!finished && cycle < 4000) begin
      @(negedge ext_clk);
      if (cycle == 0) begin
        bus.ext_buf_out_hasdata = 1'b1;
        bus.ext_buf_out_len     = 10'(len);
        drain_en                = 1'b1;
      end
      if (cycle == 5) drain_en = 1'b0;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = cycle[0];
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (err_overlen) ov_cnt++;
      if (err_arm_timeout) to_cnt++;
      if (cycle == 2 && exp_beats > 0)
        checkOutput("first_addr", 32'(bus.ext_buf_out_addr), 0);
      if (cycle >= 2 && int'(bus.ext_buf_out_addr) > max_addr)
        max_addr = int'(bus.ext_buf_out_addr);
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cycle;
        if (prev_stall) begin
          checkOutput("stall_data", 32'(bus.out_data), 32'(prev_data));
          checkOutput("stall_last", 32'(bus.out_last), 32'(prev_last));
        end
        if (bus.out_ready) begin
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checkOutput("beat_data", 32'(bus.out_data), 32'(want));
          checkOutput("beat_last", 32'(bus.out_last), 32'(exp_q.size() == 0));
          beats++;
          last_beat = cycle;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (pkt_done) begin
        done_cnt++;
        done_cycle = cycle;
        checkOutput("pkt_len", 32'(pkt_len), 32'(exp_pkt_len));
        checkOutput("beats_at_done", 32'(beats), 32'(exp_beats));
      end
      if (bus.ext_buf_out_arm) begin
        bus.ext_buf_out_hasdata = 1'b0;
        if (!bus.ext_buf_out_arm_ack) begin
          if (arm_cnt >= ack_delay) bus.ext_buf_out_arm_ack = 1'b1;
          arm_cnt++;
        end
      end else if (bus.ext_buf_out_arm_ack) begin
        bus.ext_buf_out_arm_ack = 1'b0;
        finished = 1;
      end
      cycle++;
    end
    checkOutput("pkt_complete", 32'(finished), 1);
    checkOutput("beat_count", 32'(beats), 32'(exp_beats));
    checkOutput("done_count", 32'(done_cnt), 1);
    checkOutput("overlen_count", 32'(ov_cnt), 32'(exp_overlen));
    checkOutput("timeout_count", 32'(to_cnt), 0);
    checkOutput("bytes_left", 32'(exp_q.size()), 0);
    if (exp_beats > 0) checkOutput("max_addr", 32'(max_addr), 32'(exp_beats - 1));
    if (ready_mode == 0) begin
      if (exp_beats > 0) begin
        checkOutput("first_valid_cycle", 32'(first_valid), 3);
        checkOutput("last_beat_cycle", 32'(last_beat), 32'(3 + exp_beats - 1));
        checkOutput("done_cycle", 32'(done_cycle), 32'(3 + exp_beats));
      end else begin
        checkOutput("zero_len_done_cycle", 32'(done_cycle), 2);
        checkOutput("zero_len_no_valid", 32'(first_valid), 32'(-1));
      end
    end
    repeat (2) begin
      @(negedge ext_clk);
      #1;
      checkOutput("idle_valid", 32'(bus.out_valid), 0);
      checkOutput("idle_arm", 32'(bus.ext_buf_out_arm), 0);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_last", 32'(bus.out_last), 0);
    checkOutput("rst_data", 32'(bus.out_data), 0);
    checkOutput("rst_arm", 32'(bus.ext_buf_out_arm), 0);
    checkOutput("rst_addr", 32'(bus.ext_buf_out_addr), 0);
    checkOutput("rst_pkt_done", 32'(pkt_done), 0);
    checkOutput("rst_timeout", 32'(err_arm_timeout), 0);
  endtask

  initial begin
    int arm_cycles;
    int pops;
    bit seen;
    reset = 1'b1;
    drain_en = 1'b0;
    bus.ext_buf_out_hasdata = 1'b0;
    bus.ext_buf_out_len = 10'd0;
    bus.ext_buf_out_arm_ack = 1'b0;
    bus.out_ready = 1'b0;
    fillMem();
    repeat (3) @(negedge ext_clk);
    #1;
    checkResetValues();
    checkOutput("rst_overlen", 32'(err_overlen), 0);
    @(negedge ext_clk);
    reset = 1'b0;

    // Table-driven packets
    vecs[0] = '{4,   0, 2, 4,   4,   1'b0};
    vecs[1] = '{512, 1, 3, 512, 512, 1'b0};
    vecs[2] = '{0,   0, 1, 0,   0,   1'b0};
    vecs[3] = '{700, 2, 2, 512, 512, 1'b1};
    vecs[4] = '{1,   0, 0, 1,   1,   1'b0};
    vecs[5] = '{513, 0, 1, 512, 512, 1'b1};
    vecs[6] = '{2,   2, 5, 2,   2,   1'b0};
    for (int v = 0; v < 7; v++) begin
      $display("[TB] vector %0d len=%0d ready_mode=%0d", v, vecs[v].len, vecs[v].ready_mode);
      applyStimulus(vecs[v].len, vecs[v].ready_mode, vecs[v].ack_delay,
                    vecs[v].exp_beats, vecs[v].exp_pkt_len, vecs[v].exp_overlen);
    end

    // Randomized packets against the length-clamping rule
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 600);
      $display("[TB] random packet %0d len=%0d", r, len);
      applyStimulus(len, 2, $urandom_range(0, 4), (len > 512) ? 512 : len,
                    (len > 512) ? 512 : len, len > 512);
    end

    // Arm acknowledge never arrives
    $display("[TB] arm timeout sequence");
    fillMem();
    arm_cycles = 0;
    seen = 0;
    @(negedge ext_clk);
    bus.ext_buf_out_hasdata = 1'b1;
    bus.ext_buf_out_len = 10'd3;
    drain_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge ext_clk);
      #1;
      if (bus.ext_buf_out_arm) begin
        bus.ext_buf_out_hasdata = 1'b0;
        arm_cycles++;
      end
      if (err_arm_timeout) begin
        seen = 1;
        checkOutput("timeout_arm_low", 32'(bus.ext_buf_out_arm), 0);
        checkOutput("timeout_valid_low", 32'(bus.out_valid), 0);
      end
    end
    checkOutput("timeout_seen", 32'(seen), 1);
    checkOutput("timeout_arm_cycles", 32'(arm_cycles), 1024);
    @(negedge ext_clk);
    #1;
    checkOutput("timeout_pulse_width", 32'(err_arm_timeout), 0);
    applyStimulus(3, 0, 1, 3, 3, 1'b0);

    // Reset while byte 100 of 300 is on the stream
    $display("[TB] reset mid-packet sequence");
    fillMem();
    pops = 0;
    seen = 0;
    @(negedge ext_clk);
    bus.ext_buf_out_hasdata = 1'b1;
    bus.ext_buf_out_len = 10'd300;
    drain_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge ext_clk);
      #1;
      if (bus.out_valid && pops == 100) begin
        checkOutput("byte100_data", 32'(bus.out_data), 32'(mem[100]));
        reset = 1'b1;
        seen = 1;
      end else if (bus.out_valid && bus.out_ready) begin
        pops++;
      end
    end
    checkOutput("reset_point_reached", 32'(seen), 1);
    @(negedge ext_clk);
    #1;
    checkResetValues();
    bus.ext_buf_out_hasdata = 1'b0;
    reset = 1'b0;
    applyStimulus(300, 0, 2, 300, 300, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
